// File: rtl/multi_norm_mult.sv
// rtl/multi_norm_mult.sv - iterative radix-2 shift-add multiplier for normalized mantissas
// Optional normalized outputs (norm_mantissa, exp_inc, sticky) enabled by MULT_NORM_OUT_EN.
module multi_norm_mult #(
  parameter int INWIDTH    = 24,
  parameter int COUNTWIDTH = $clog2(INWIDTH)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   mode,
  input  logic                   start,
  input  logic [INWIDTH-1:0]     multiplicand_in,
  input  logic [INWIDTH-1:0]     multiplier_in,
  output logic                   busy,
  output logic                   done,
  output logic [2*INWIDTH-1:0]   product
`ifdef MULT_NORM_OUT_EN
  ,
  output logic [INWIDTH-1:0]     norm_mantissa,
  output logic                   exp_inc,
  output logic                   sticky
`endif
);

  typedef enum logic {IDLE, CALC} state_t;

  localparam logic [COUNTWIDTH:0] LAST_COUNT = (COUNTWIDTH+1)'(INWIDTH);
  localparam logic [COUNTWIDTH:0] FIRST_COUNT = (COUNTWIDTH+1)'(1);

  state_t                state;
  logic [COUNTWIDTH:0]   count;
  logic [INWIDTH-1:0]    multiplicand;
  logic [INWIDTH-1:0]    multiplier;
  logic [INWIDTH:0]      sum;
  logic [2*INWIDTH-1:0]  next_product;

  // The adder carry becomes the new MSB after the shift, so the result stays exact.
  always_comb begin
    sum          = {1'b0, product[2*INWIDTH-1:INWIDTH]}
                 + {1'b0, multiplicand & {INWIDTH{multiplier[0]}}};
    next_product = {sum, product[INWIDTH-1:1]};
  end

`ifdef MULT_NORM_OUT_EN
  logic [INWIDTH-1:0] norm_next;
  logic               sticky_next;

  always_comb begin
    norm_next   = '0;
    sticky_next = 1'b0;
    if (next_product[2*INWIDTH-1]) begin
      norm_next   = next_product[2*INWIDTH-1:INWIDTH];
      sticky_next = |next_product[INWIDTH-1:0];
    end else begin
      norm_next   = next_product[2*INWIDTH-2:INWIDTH-1];
      sticky_next = |next_product[INWIDTH-2:0];
    end
  end
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      busy         <= 1'b0;
      done         <= 1'b0;
      product      <= '0;
      count        <= '0;
      multiplicand <= '0;
      multiplier   <= '0;
`ifdef MULT_NORM_OUT_EN
      norm_mantissa <= '0;
      exp_inc       <= 1'b0;
      sticky        <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            multiplicand <= multiplicand_in;
            multiplier   <= mode ? multiplicand_in : multiplier_in;
            product      <= '0;
            count        <= FIRST_COUNT;
            busy         <= 1'b1;
            state        <= CALC;
          end
        end
        CALC: begin
          product    <= next_product;
          multiplier <= multiplier >> 1;
          if (count == LAST_COUNT) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
`ifdef MULT_NORM_OUT_EN
            norm_mantissa <= norm_next;
            exp_inc       <= next_product[2*INWIDTH-1];
            sticky        <= sticky_next;
`endif
          end else begin
            count <= count + 1'b1;
            busy  <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_multi_norm_mult.sv
// tb/tb_multi_norm_mult.sv - self-checking bench for multi_norm_mult (INWIDTH = 24)
// Norm-output checks are compiled in only when MULT_NORM_OUT_EN is defined.
module tb_multi_norm_mult;

  localparam int W = 24;

  logic           clk;
  logic           reset;
  logic           mode;
  logic           start;
  logic [W-1:0]   mcand;
  logic [W-1:0]   mplier;
  logic           busy;
  logic           done;
  logic [2*W-1:0] product;
`ifdef MULT_NORM_OUT_EN
  logic [W-1:0]   norm_mantissa;
  logic           exp_inc;
  logic           sticky;
`endif

  int n_cmp = 0;
  int n_err = 0;

  multi_norm_mult #(.INWIDTH(W)) dut (
    .clk             (clk),
    .reset           (reset),
    .mode            (mode),
    .start           (start),
    .multiplicand_in (mcand),
    .multiplier_in   (mplier),
    .busy            (busy),
    .done            (done),
    .product         (product)
`ifdef MULT_NORM_OUT_EN
    ,
    .norm_mantissa   (norm_mantissa),
    .exp_inc         (exp_inc),
    .sticky          (sticky)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [2*W-1:0] got, input logic [2*W-1:0] want);
    n_cmp++;
    assert (got === want) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, got, want);
    end
  endtask

  function automatic logic [2*W-1:0] ref_product(input logic m, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [2*W-1:0] x, y;
    x = {{W{1'b0}}, a};
    y = m ? {{W{1'b0}}, a} : {{W{1'b0}}, b};
    return x * y;
  endfunction

  // Checks the final-cycle outputs against the arithmetic product p.
  task automatic chk_result(input string tag, input logic [2*W-1:0] p);
    chk({tag, "_done"}, {46'd0, busy, done}, 48'b01);
    chk({tag, "_product"}, product, p);
    chk({tag, "_range"}, {47'd0, product[2*W-1:2*W-2] != 2'b00}, 48'd1);
`ifdef MULT_NORM_OUT_EN
    begin
      logic [W-1:0] nm;
      logic         st;
      if (p[2*W-1]) begin
        nm = p[2*W-1:W];
        st = (p[W-1:0] != 0);
      end else begin
        nm = p[2*W-2:W-1];
        st = (p[W-2:0] != 0);
      end
      chk({tag, "_exp_inc"}, {47'd0, exp_inc}, {47'd0, p[2*W-1]});
      chk({tag, "_norm"}, {24'd0, norm_mantissa}, {24'd0, nm});
      chk({tag, "_sticky"}, {47'd0, sticky}, {47'd0, st});
    end
`endif
  endtask

  // One full operation with inputs scrambled and start toggled while busy.
  task automatic run_op(input string tag, input logic m, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [2*W-1:0] p;
    p = ref_product(m, a, b);
    @(negedge clk);
    mode = m; mcand = a; mplier = b; start = 1'b1;
    for (int i = 1; i <= W; i++) begin
      @(negedge clk);
      chk({tag, "_busy_window"}, {46'd0, busy, done}, 48'b10);
      mode = 1'($urandom); mcand = W'($urandom); mplier = W'($urandom); start = 1'($urandom);
    end
    @(negedge clk);
    start = 1'b0;
    chk_result(tag, p);
    @(negedge clk);
    chk({tag, "_idle_after"}, {46'd0, busy, done}, 48'b00);
    chk({tag, "_hold"}, product, p);
  endtask

  function automatic logic [W-1:0] rand_norm();
    return W'($urandom) | {1'b1, {(W-1){1'b0}}};
  endfunction

  initial begin
    logic [W-1:0]   a1, b1, a2, b2;
    logic           m1;
    logic [2*W-1:0] p1, p2;

    reset = 1'b1; start = 1'b0; mode = 1'b0; mcand = '0; mplier = '0;
    #1;
    chk("reset_busy_done", {46'd0, busy, done}, 48'b00);
    chk("reset_product", product, 48'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    run_op("min_x_min", 1'b0, 24'h800000, 24'h800000);
    chk("min_x_min_const", product, 48'h400000000000);
    run_op("square_c0", 1'b1, 24'hC00000, 24'h800000);
    chk("square_c0_const", product, 48'h900000000000);
    run_op("max_x_max", 1'b0, 24'hFFFFFF, 24'hFFFFFF);
    chk("max_x_max_const", product, 48'hFFFFFE000001);

    for (int k = 0; k < 12; k++) begin
      run_op("random", 1'($urandom), rand_norm(), rand_norm());
    end

    // start held high: second operation accepted in the done cycle
    a1 = rand_norm(); b1 = rand_norm(); m1 = 1'($urandom);
    a2 = rand_norm(); b2 = rand_norm();
    p1 = ref_product(m1, a1, b1);
    p2 = ref_product(1'b0, a2, b2);
    @(negedge clk);
    mode = m1; mcand = a1; mplier = b1; start = 1'b1;
    for (int i = 1; i <= W; i++) begin
      @(negedge clk);
      chk("b2b_busy1", {46'd0, busy, done}, 48'b10);
    end
    @(negedge clk);
    chk_result("b2b_first", p1);
    mode = 1'b0; mcand = a2; mplier = b2;
    @(negedge clk);
    chk("b2b_restart", {46'd0, busy, done}, 48'b10);
    start = 1'b0;
    for (int i = 2; i <= W; i++) begin
      @(negedge clk);
      chk("b2b_busy2", {46'd0, busy, done}, 48'b10);
    end
    @(negedge clk);
    chk_result("b2b_second", p2);
    @(negedge clk);
    chk("b2b_no_third", {46'd0, busy, done}, 48'b00);

    // reset in cycle 10 of an operation
    @(negedge clk);
    mode = 1'b0; mcand = rand_norm(); mplier = rand_norm(); start = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      start = 1'b0;
    end
    reset = 1'b1;
    #1;
    chk("abort_busy_done", {46'd0, busy, done}, 48'b00);
    chk("abort_product", product, 48'd0);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      chk("abort_quiet", {46'd0, busy, done}, 48'b00);
    end
    run_op("after_abort", 1'b0, rand_norm(), rand_norm());
    run_op("after_abort_sq", 1'b1, rand_norm(), rand_norm());

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/multi_norm_mult.md
MULTI_NORM_MULT -- requirements
Module: multi_norm_mult

Interface
REQ-001 SHALL have parameter INWIDTH, default 24: operand width; operands are normalized mantissas 1.xxx...x with MSB = 1.
REQ-002 SHALL have parameter COUNTWIDTH, default $clog2(INWIDTH): iteration counter width is COUNTWIDTH+1 bits.
REQ-003 SHALL have port clk, input, 1: clock, rising-edge active.
REQ-004 SHALL have port reset, input, 1: reset, asynchronous, active-high.
REQ-005 SHALL have port mode, input, 1: operation select; 0 = multiply, 1 = square; sampled with start.
REQ-006 SHALL have port start, input, 1: request; accepted only in IDLE.
REQ-007 SHALL have port multiplicand_in, input, INWIDTH: first operand; the sole operand in square mode.
REQ-008 SHALL have port multiplier_in, input, INWIDTH: second operand; ignored when mode = 1.
REQ-009 SHALL have port busy, output, 1: registered; high while iterating.
REQ-010 SHALL have port done, output, 1: registered; one-cycle pulse when product is final.
REQ-011 SHALL have port product, output, 2*INWIDTH: registered full-precision product.

Function
REQ-012 SHALL implement a two-state FSM, IDLE and CALC, with an iterative radix-2 shift-add multiplier (one partial product per cycle).
REQ-013 IDLE with start = 1 SHALL load the multiplicand register from multiplicand_in and the multiplier shift register from multiplier_in (mode = 0) or multiplicand_in (mode = 1), clear product, set count = 1, set busy_next = 1, go to CALC.
REQ-014 Each CALC cycle SHALL form {carry, upper} = product[2*INWIDTH-1:INWIDTH] + (multiplier LSB ? multiplicand : 0), then shift {carry, upper, product[INWIDTH-1:0]} right by one into product, and shift the multiplier register right by one.
REQ-015 The carry bit SHALL be retained through the shift; no product bit is lost; the result is exact.
REQ-016 CALC with count != INWIDTH SHALL set busy_next = 1, increment count, stay in CALC.
REQ-017 CALC with count == INWIDTH SHALL perform the final iteration, set done_next = 1, busy_next = 0, go to IDLE.
REQ-018 Latency: start accepted at edge 0; busy high cycles 1..INWIDTH; done high in cycle INWIDTH+1 only; product final in that cycle.
REQ-019 product SHALL hold its final value from done until the next accepted start; mid-operation values are partial and undefined for use.
REQ-020 start while busy = 1 SHALL be ignored; mode and operand changes during CALC SHALL have no effect.
REQ-021 start asserted in the done cycle SHALL be accepted (FSM is in IDLE); busy rises the following cycle.
REQ-022 For normalized operands, product[2*INWIDTH-1:2*INWIDTH-2] SHALL never be 00 (result in [1,4)).

Reset
REQ-023 Reset SHALL force state = IDLE, busy = 0, done = 0, product = 0, count = 0, and clear the multiplicand and multiplier registers, asynchronously.
REQ-024 Reset mid-operation SHALL abort; no done pulse SHALL follow; the next start after release SHALL behave per REQ-013.

Configuration
REQ-025 Macro MULT_NORM_OUT_EN SHALL, when defined, add registered outputs norm_mantissa (INWIDTH), exp_inc (1), sticky (1), updated on the same edge as done.
REQ-026 With MULT_NORM_OUT_EN: if the final product MSB = 1 then exp_inc = 1, norm_mantissa = product[2*INWIDTH-1:INWIDTH], sticky = OR of product[INWIDTH-1:0]; else exp_inc = 0, norm_mantissa = product[2*INWIDTH-2:INWIDTH-1], sticky = OR of product[INWIDTH-2:0]; all reset to 0 and hold until the next done.
REQ-027 Without MULT_NORM_OUT_EN these ports and their logic SHALL be absent; all other behaviour is identical.

Verification (INWIDTH = 24)
REQ-028 mode = 0, 0x800000 x 0x800000 -> done in cycle 25, product = 0x400000000000; exp_inc = 0, norm_mantissa = 0x800000, sticky = 0.
REQ-029 mode = 1, multiplicand_in = 0xC00000, multiplier_in = 0x800000 -> product = 0x900000000000; exp_inc = 1, norm_mantissa = 0x900000, sticky = 0.
REQ-030 mode = 0, 0xFFFFFF x 0xFFFFFF -> product = 0xFFFFFE000001; exp_inc = 1, norm_mantissa = 0xFFFFFE, sticky = 1.
REQ-031 start held high through a whole operation -> a second start accepted in the done cycle; busy low for exactly that cycle; a new done 25 cycles later.
REQ-032 reset pulsed at cycle 10 of an operation -> busy = 0, done = 0, product = 0 immediately; no done pulse afterwards; the next operation is correct.
